// File: rtl/door_array_if.sv
// door_array_if: bundles the door controller's pixel, player, door-map and
// status signals. The master side (player-motion logic / sequencer) drives
// positions and level_clr; the slave side (door_array) returns pixel hits,
// reach flags, animation frames and level status.
interface door_array_if #(
  parameter int unsigned NUM_DOORS   = 2,
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned ANIM_FRAMES = 4
);
  localparam int unsigned OwnerW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int unsigned FrameW = $clog2(ANIM_FRAMES);

  // Pixel scan and player state
  logic [9:0]              DrawX;
  logic [9:0]              DrawY;
  logic [9:0]              BallX       [NUM_PLAYERS];
  logic [9:0]              BallY       [NUM_PLAYERS];
  logic [9:0]              Collision_h;

  // Door map, in 16-pixel tiles
  logic [9:0]              door_row    [NUM_DOORS];
  logic [9:0]              door_col    [NUM_DOORS];
  logic [OwnerW-1:0]       door_owner  [NUM_DOORS];

  logic                    level_clr;

  // Door status
  logic [NUM_DOORS-1:0]    on;
  logic [NUM_DOORS-1:0]    reach;
  logic [FrameW-1:0]       anim_frame  [NUM_DOORS];
  logic [NUM_DOORS-1:0]    door_open;
  logic                    level_done;

  modport master (
    output DrawX, DrawY, BallX, BallY, Collision_h,
    output door_row, door_col, door_owner, level_clr,
    input  on, reach, anim_frame, door_open, level_done
  );

  modport slave (
    input  DrawX, DrawY, BallX, BallY, Collision_h,
    input  door_row, door_col, door_owner, level_clr,
    output on, reach, anim_frame, door_open, level_done
  );
endinterface

// File: rtl/door_array.sv
// door_array: exit-door controller for NUM_DOORS doors and NUM_PLAYERS sprites.
// Per frame it registers which doors are occupied, animates each door through
// CLOSED/OPENING/OPEN/CLOSING, counts dwell while an open door stays occupied
// and raises a sticky level_done once every door is open with full dwell.
//
// Build option: define DOOR_OWNER_EN so that door d only accepts player
// door_owner[d]; without it any player opens any door and door_owner is ignored.
module door_array #(
  parameter int unsigned NUM_DOORS    = 2,
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned DOOR_W       = 32,
  parameter int unsigned DOOR_H       = 32,
  parameter int unsigned ANIM_FRAMES  = 4,
  parameter int unsigned ANIM_PERIOD  = 8,
  parameter int unsigned DWELL_FRAMES = 30
) (
  input logic         frame_clk,
  input logic         RESET,
  door_array_if.slave bus
);

  localparam int unsigned OwnerW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int unsigned FrameW = $clog2(ANIM_FRAMES);
  localparam int unsigned TickW  = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
  localparam int unsigned DwellW = $clog2(DWELL_FRAMES + 1);

  localparam logic [11:0]        DoorW12   = 12'(DOOR_W);
  localparam logic [11:0]        DoorH12   = 12'(DOOR_H);
  localparam logic [FrameW-1:0]  LastFrame = FrameW'(ANIM_FRAMES - 1);
  localparam logic [TickW-1:0]   LastTick  = TickW'(ANIM_PERIOD - 1);
  localparam logic [DwellW-1:0]  DwellMax  = DwellW'(DWELL_FRAMES);

  typedef enum logic [1:0] {
    StClosed,
    StOpening,
    StOpen,
    StClosing
  } door_state_e;

  // Player-on-door test. Everything is widened to 12 bits so the offsets
  // cannot wrap; a collision height taller than the door row clamps the
  // lower edge at zero instead of underflowing.
  function automatic logic player_hit(
    input logic [9:0] col,
    input logic [9:0] row,
    input logic [9:0] bx,
    input logic [9:0] by,
    input logic [9:0] ch
  );
    logic [11:0] px;
    logic [11:0] py;
    logic [11:0] cx;
    logic [11:0] cy;
    logic [11:0] lo_y;
    px   = 12'({col, 4'h0});
    py   = 12'({row, 4'h0});
    cx   = 12'(bx) + 12'd25;
    cy   = 12'(by) + 12'd7;
    lo_y = (py < 12'(ch)) ? 12'd0 : (py - 12'(ch));
    player_hit = (px < cx) && (cx < (px + DoorW12)) &&
                 (lo_y < cy) && (cy < (py + DoorH12));
  endfunction

  // Door sprite pixel test. The sprite sits one tile above the door row;
  // shifting DrawY down one tile keeps the compare free of negative values.
  function automatic logic pixel_hit(
    input logic [9:0] col,
    input logic [9:0] row,
    input logic [9:0] dx,
    input logic [9:0] dy
  );
    logic [11:0] ox;
    logic [11:0] oy;
    logic [11:0] x;
    logic [11:0] y;
    ox = 12'({col, 4'h0});
    oy = 12'({row, 4'h0});
    x  = 12'(dx);
    y  = 12'(dy) + 12'd16;
    pixel_hit = (x >= ox) && (x < (ox + DoorW12)) &&
                (y >= oy) && (y < (oy + DoorH12));
  endfunction

  // Whether door d listens to player p.
  function automatic logic accepts(input logic [OwnerW-1:0] owner, input int p);
`ifdef DOOR_OWNER_EN
    accepts = (owner == OwnerW'(p));
`else
    accepts = (owner == owner);
`endif
  endfunction

  logic [NUM_DOORS-1:0] on_hit;
  logic [NUM_DOORS-1:0] reach_d;
  logic [NUM_DOORS-1:0] reach_q;
  logic                 all_done;
  logic                 done_q;

  door_state_e          state_q [NUM_DOORS];
  logic [TickW-1:0]     tick_q  [NUM_DOORS];
  logic [FrameW-1:0]    frame_q [NUM_DOORS];
  logic [DwellW-1:0]    dwell_q [NUM_DOORS];
  logic [NUM_DOORS-1:0] open_q;

  // Combinational door sprite hit for the colour mapper.
  always_comb begin
    on_hit = '0;
    for (int d = 0; d < NUM_DOORS; d++) begin
      on_hit[d] = pixel_hit(bus.door_col[d], bus.door_row[d], bus.DrawX, bus.DrawY);
    end
  end

  // OR of player hits over the players each door accepts.
  always_comb begin
    reach_d = '0;
    for (int d = 0; d < NUM_DOORS; d++) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (accepts(bus.door_owner[d], p) &&
            player_hit(bus.door_col[d], bus.door_row[d], bus.BallX[p], bus.BallY[p],
                       bus.Collision_h)) begin
          reach_d[d] = 1'b1;
        end
      end
    end
  end

  // Register occupancy once per frame; the FSMs only ever see this copy.
  always_ff @(posedge frame_clk or posedge RESET) begin
    if (RESET) begin
      reach_q <= '0;
    end else begin
      reach_q <= reach_d;
    end
  end

  // Per-door animation FSM with dwell counter and registered door_open.
  always_ff @(posedge frame_clk or posedge RESET) begin
    if (RESET) begin
      for (int d = 0; d < NUM_DOORS; d++) begin
        state_q[d] <= StClosed;
        tick_q[d]  <= '0;
        frame_q[d] <= '0;
        dwell_q[d] <= '0;
      end
      open_q <= '0;
    end else begin
      for (int d = 0; d < NUM_DOORS; d++) begin
        unique case (state_q[d])
          StClosed: begin
            if (reach_q[d]) begin
              state_q[d] <= StOpening;
              tick_q[d]  <= '0;
              frame_q[d] <= '0;
            end
          end
          StOpening: begin
            if (!reach_q[d]) begin
              // Reverse in place: frame and tick carry over.
              state_q[d] <= StClosing;
            end else if (frame_q[d] == LastFrame) begin
              // Only reachable by reversing out of CLOSING at the last frame.
              state_q[d] <= StOpen;
              tick_q[d]  <= '0;
              dwell_q[d] <= '0;
              open_q[d]  <= 1'b1;
            end else if (tick_q[d] == LastTick) begin
              tick_q[d]  <= '0;
              frame_q[d] <= frame_q[d] + 1'b1;
              if (frame_q[d] == LastFrame - 1'b1) begin
                state_q[d] <= StOpen;
                dwell_q[d] <= '0;
                open_q[d]  <= 1'b1;
              end
            end else begin
              tick_q[d] <= tick_q[d] + 1'b1;
            end
          end
          StOpen: begin
            if (!reach_q[d]) begin
              state_q[d] <= StClosing;
              dwell_q[d] <= '0;
              open_q[d]  <= 1'b0;
            end else if (dwell_q[d] != DwellMax) begin
              dwell_q[d] <= dwell_q[d] + 1'b1;
            end
          end
          StClosing: begin
            if (reach_q[d]) begin
              state_q[d] <= StOpening;
            end else if (frame_q[d] == '0) begin
              // Only reachable by reversing out of OPENING at frame 0.
              state_q[d] <= StClosed;
              tick_q[d]  <= '0;
            end else if (tick_q[d] == LastTick) begin
              tick_q[d]  <= '0;
              frame_q[d] <= frame_q[d] - 1'b1;
              if (frame_q[d] == FrameW'(1)) begin
                state_q[d] <= StClosed;
              end
            end else begin
              tick_q[d] <= tick_q[d] + 1'b1;
            end
          end
          default: begin
            state_q[d] <= StClosed;
            open_q[d]  <= 1'b0;
          end
        endcase
        // level_clr overrides any dwell update from the FSM above.
        if (bus.level_clr) begin
          dwell_q[d] <= '0;
        end
      end
    end
  end

  // True when every door is open and has dwelt long enough.
  always_comb begin
    all_done = 1'b1;
    for (int d = 0; d < NUM_DOORS; d++) begin
      if (!((state_q[d] == StOpen) && (dwell_q[d] == DwellMax))) begin
        all_done = 1'b0;
      end
    end
  end

  // Sticky level-complete; a clear on the same edge wins over a set.
  always_ff @(posedge frame_clk or posedge RESET) begin
    if (RESET) begin
      done_q <= 1'b0;
    end else if (bus.level_clr) begin
      done_q <= 1'b0;
    end else if (all_done) begin
      done_q <= 1'b1;
    end
  end

  assign bus.on         = on_hit;
  assign bus.reach      = reach_q;
  assign bus.anim_frame = frame_q;
  assign bus.door_open  = open_q;
  assign bus.level_done = done_q;

endmodule

// File: tb/tb_door_array.sv
// tb_door_array: table-driven hit vectors, hand-timed animation/level
// sequences and a randomized run, all checked against a behavioural model.
module tb_door_array;

  localparam int ND = 2;
  localparam int NP = 2;
  localparam int DW = 32;
  localparam int DH = 32;
  localparam int AF = 4;
  localparam int AP = 8;
  localparam int DF = 30;

  localparam int M_CLOSED  = 0;
  localparam int M_OPENING = 1;
  localparam int M_OPEN    = 2;
  localparam int M_CLOSING = 3;

  logic frame_clk = 1'b0;
  logic RESET     = 1'b1;

  door_array_if #(.NUM_DOORS(ND), .NUM_PLAYERS(NP), .ANIM_FRAMES(AF)) bus ();

  door_array #(
    .NUM_DOORS   (ND),
    .NUM_PLAYERS (NP),
    .DOOR_W      (DW),
    .DOOR_H      (DH),
    .ANIM_FRAMES (AF),
    .ANIM_PERIOD (AP),
    .DWELL_FRAMES(DF)
  ) dut (
    .frame_clk(frame_clk),
    .RESET    (RESET),
    .bus      (bus)
  );

  always #5 frame_clk = ~frame_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_state [ND];
  int m_frame [ND];
  int m_tick  [ND];
  int m_dwell [ND];
  int m_reach [ND];
  int m_done;

  typedef struct {
    int bx;
    int by;
    int ch;
    int dx;
    int dy;
    int exp_reach;
    int exp_on;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int hit(int col, int row, int bx, int by, int ch);
    int px = col * 16;
    int py = row * 16;
    int lo = (py < ch) ? 0 : py - ch;
    return ((px < bx + 25) && (bx + 25 < px + DW) && (lo < by + 7) && (by + 7 < py + DH))
           ? 1 : 0;
  endfunction

  function automatic int on_model(int d);
    int ox = int'(bus.door_col[d]) * 16;
    int oy = (int'(bus.door_row[d]) - 1) * 16;
    int x  = int'(bus.DrawX);
    int y  = int'(bus.DrawY);
    return ((x >= ox) && (x < ox + DW) && (y >= oy) && (y < oy + DH)) ? 1 : 0;
  endfunction

  function automatic int accepts(int d, int p);
`ifdef DOOR_OWNER_EN
    return (int'(bus.door_owner[d]) == p) ? 1 : 0;
`else
    return (d >= 0 && p >= 0) ? 1 : 0;
`endif
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_state[d] = M_CLOSED;
      m_frame[d] = 0;
      m_tick[d]  = 0;
      m_dwell[d] = 0;
      m_reach[d] = 0;
    end
    m_done = 0;
  endtask

  // Animation position tracked as elapsed ticks in the current direction.
  task automatic model_fsm(input int d);
    int pos;
    case (m_state[d])
      M_CLOSED: if (m_reach[d] != 0) begin
        m_state[d] = M_OPENING;
        m_frame[d] = 0;
        m_tick[d]  = 0;
      end
      M_OPENING: if (m_reach[d] == 0) begin
        m_state[d] = M_CLOSING;
      end else begin
        if (m_frame[d] < AF - 1) begin
          pos = m_frame[d] * AP + m_tick[d] + 1;
          m_frame[d] = pos / AP;
          m_tick[d]  = pos % AP;
        end
        if (m_frame[d] == AF - 1) begin
          m_state[d] = M_OPEN;
          m_tick[d]  = 0;
          m_dwell[d] = 0;
        end
      end
      M_OPEN: if (m_reach[d] == 0) begin
        m_state[d] = M_CLOSING;
        m_dwell[d] = 0;
      end else if (m_dwell[d] < DF) begin
        m_dwell[d]++;
      end
      default: if (m_reach[d] != 0) begin
        m_state[d] = M_OPENING;
      end else begin
        if (m_frame[d] > 0) begin
          pos = (AF - 1 - m_frame[d]) * AP + m_tick[d] + 1;
          m_frame[d] = AF - 1 - pos / AP;
          m_tick[d]  = pos % AP;
        end
        if (m_frame[d] == 0) begin
          m_state[d] = M_CLOSED;
          m_tick[d]  = 0;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    for (int d = 0; d < ND; d++) begin
      check($sformatf("reach[%0d]", d), int'(bus.reach[d]), m_reach[d]);
      check($sformatf("anim_frame[%0d]", d), int'(bus.anim_frame[d]), m_frame[d]);
      check($sformatf("door_open[%0d]", d), int'(bus.door_open[d]),
            (m_state[d] == M_OPEN) ? 1 : 0);
    end
    check("level_done", int'(bus.level_done), m_done);
  endtask

  // Advance the model on the inputs present now, clock once, then compare.
  task automatic step();
    int nr [ND];
    int all_ok = 1;
    for (int d = 0; d < ND; d++) begin
      if (!(m_state[d] == M_OPEN && m_dwell[d] == DF)) all_ok = 0;
      nr[d] = 0;
      for (int p = 0; p < NP; p++) begin
        if (accepts(d, p) != 0 &&
            hit(int'(bus.door_col[d]), int'(bus.door_row[d]), int'(bus.BallX[p]),
                int'(bus.BallY[p]), int'(bus.Collision_h)) != 0) nr[d] = 1;
      end
    end
    for (int d = 0; d < ND; d++) model_fsm(d);
    if (bus.level_clr) begin
      for (int d = 0; d < ND; d++) m_dwell[d] = 0;
      m_done = 0;
    end else if (all_ok != 0) begin
      m_done = 1;
    end
    for (int d = 0; d < ND; d++) m_reach[d] = nr[d];
    @(posedge frame_clk);
    #1;
    compare_all();
  endtask

  // Asynchronous reset between edges; outputs must clear with no clock.
  task automatic do_reset();
    #2 RESET = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge frame_clk);
    RESET = 1'b0;
  endtask

  task automatic place(input int p, input int bx, input int by);
    bus.BallX[p] = 10'(bx);
    bus.BallY[p] = 10'(by);
  endtask

  initial begin
    vecs[0] = '{510,  90,  32, 528, 64, 1, 1};
    vecs[1] = '{503,  90,  32, 527, 64, 0, 0};
    vecs[2] = '{504,  90,  32, 559, 95, 1, 1};
    vecs[3] = '{510, 105,  32, 560, 80, 0, 0};
    vecs[4] = '{510, 104,  32, 540, 63, 1, 0};
    vecs[5] = '{534,  42,  32, 540, 96, 1, 0};
    vecs[6] = '{535,  42,  32, 528, 95, 0, 1};
    vecs[7] = '{510,  41,  32, 545, 70, 0, 1};
    vecs[8] = '{510,   0, 100,   0,  0, 1, 0};
    vecs[9] = '{510,   0,  32, 600, 80, 0, 0};

    bus.DrawX       = '0;
    bus.DrawY       = '0;
    bus.Collision_h = 10'd32;
    bus.level_clr   = 1'b0;
    bus.door_row[0] = 10'd5;
    bus.door_col[0] = 10'd33;
    bus.door_row[1] = 10'd5;
    bus.door_col[1] = 10'd35;
    bus.door_owner[0] = 1'b0;
    bus.door_owner[1] = 1'b1;
    place(0, 0, 0);
    place(1, 0, 0);
    model_reset();

    // Hit-test and pixel-test table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      place(0, vecs[i].bx, vecs[i].by);
      bus.Collision_h = 10'(vecs[i].ch);
      bus.DrawX = 10'(vecs[i].dx);
      bus.DrawY = 10'(vecs[i].dy);
      #1;
      check($sformatf("vec%0d_on0", i), int'(bus.on[0]), vecs[i].exp_on);
      step();
      check($sformatf("vec%0d_reach0", i), int'(bus.reach[0]), vecs[i].exp_reach);
    end
    bus.Collision_h = 10'd32;

    // Ownership filter
    do_reset();
    bus.door_owner[0] = 1'b1;
    place(0, 510, 90);
    step();
`ifdef DOOR_OWNER_EN
    check("owner_reach0", int'(bus.reach[0]), 0);
`else
    check("owner_reach0", int'(bus.reach[0]), 1);
`endif
    bus.door_owner[0] = 1'b0;

    // Reset in the middle of OPENING at frame 2
    place(0, 0, 0);
    do_reset();
    place(0, 510, 90);
    for (int e = 1; e <= 20; e++) step();
    check("pre_reset_frame", int'(bus.anim_frame[0]), 2);
    do_reset();
    check("reset_frame0", int'(bus.anim_frame[0]), 0);

    // Opening timeline from cycle 0
    for (int e = 1; e <= 27; e++) begin
      step();
      if (e == 1)  check("open_reach_e1", int'(bus.reach[0]), 1);
      if (e == 9)  check("open_frame_e9", int'(bus.anim_frame[0]), 0);
      if (e == 10) check("open_frame_e10", int'(bus.anim_frame[0]), 1);
      if (e == 18) check("open_frame_e18", int'(bus.anim_frame[0]), 2);
      if (e == 25) check("open_door_e25", int'(bus.door_open[0]), 0);
      if (e == 26) check("open_frame_e26", int'(bus.anim_frame[0]), 3);
      if (e == 26) check("open_door_e26", int'(bus.door_open[0]), 1);
    end

    // Leave at frame 2, close fully
    place(0, 0, 0);
    do_reset();
    place(0, 510, 90);
    for (int e = 1; e <= 36; e++) begin
      step();
      if (e == 18) place(0, 0, 0);
      if (e == 26) check("close_frame_e26", int'(bus.anim_frame[0]), 2);
      if (e == 27) check("close_frame_e27", int'(bus.anim_frame[0]), 1);
      if (e == 35) check("close_frame_e35", int'(bus.anim_frame[0]), 0);
    end

    // Leave at frame 2, come back mid-CLOSING
    do_reset();
    place(0, 510, 90);
    for (int e = 1; e <= 45; e++) begin
      step();
      if (e == 18) place(0, 0, 0);
      if (e == 30) place(0, 510, 90);
      if (e == 35) check("reopen_frame_e35", int'(bus.anim_frame[0]), 1);
      if (e == 36) check("reopen_frame_e36", int'(bus.anim_frame[0]), 2);
      if (e == 44) check("reopen_open_e44", int'(bus.door_open[0]), 1);
    end

    // Both doors occupied: level_done 31 edges after OPEN
    place(0, 0, 0);
    do_reset();
    place(0, 510, 90);
    place(1, 545, 90);
    for (int e = 1; e <= 58; e++) begin
      step();
      if (e == 26) check("both_open_e26", int'(bus.door_open), 3);
      if (e == 56) check("done_e56", int'(bus.level_done), 0);
      if (e == 57) check("done_e57", int'(bus.level_done), 1);
    end

    // level_clr on the setting edge wins, then dwell restarts
    do_reset();
    for (int e = 1; e <= 89; e++) begin
      bus.level_clr = (e == 57);
      step();
      if (e == 57) check("clr_done_e57", int'(bus.level_done), 0);
      if (e == 87) check("clr_done_e87", int'(bus.level_done), 0);
      if (e == 88) check("clr_done_e88", int'(bus.level_done), 1);
    end
    bus.level_clr = 1'b0;

    // Randomized run
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 63) == 0) begin
          case ($urandom_range(0, 3))
            0: place(p, int'($urandom_range(505, 530)), int'($urandom_range(45, 100)));
            1: place(p, int'($urandom_range(537, 565)), int'($urandom_range(45, 100)));
            2: place(p, int'($urandom_range(495, 575)), int'($urandom_range(35, 115)));
            default: place(p, int'($urandom_range(0, 400)), int'($urandom_range(0, 30)));
          endcase
        end
      end
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 2))
          0: bus.Collision_h = 10'd16;
          1: bus.Collision_h = 10'd32;
          default: bus.Collision_h = 10'd90;
        endcase
      end
      bus.level_clr = ($urandom_range(0, 39) == 0);
      bus.DrawX = 10'($urandom_range(500, 610));
      bus.DrawY = 10'($urandom_range(50, 110));
      #1;
      for (int d = 0; d < ND; d++) begin
        check($sformatf("rand_on[%0d]", d), int'(bus.on[d]), on_model(d));
      end
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
